// File: rtl/bus_scheduler.sv
// Two-master serial bus scheduler: priority/round-robin grant, CLEAR hand-off,
// priority preemption (STOP_P) and contention-timeout split (STOP_S).
//
// state   | meaning
// IDLE    | bus free, arbitrating valid requests
// GRANT   | CLEAR driven to the winner for one cycle
// ACK     | waiting for the winner to report com (or nak / ack timeout)
// COM     | winner owns the bus; watch for end_com, preemption, split timeout
// STOP    | STOP_P/STOP_S held until the owner reports end_com
// RELEASE | bus select cleared, round-robin pointer updated
module bus_scheduler #(
  parameter int TIMEOUT = 100
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] slave0,
  input  logic [1:0] slave1,
  input  logic       prio0,
  input  logic       prio1,
  input  logic [1:0] state0,
  input  logic [1:0] state1,
  output logic [1:0] cmd0,
  output logic [1:0] cmd1,
  output logic [2:0] bus_state,
  output logic       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT   = 3'd1;
  localparam logic [2:0] S_ACK     = 3'd2;
  localparam logic [2:0] S_COM     = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  localparam logic [1:0] ST_END  = 2'b00;
  localparam logic [1:0] ST_NAK  = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;
  localparam logic [1:0] ST_COM  = 2'b11;

  localparam logic [1:0] CMD_WAIT   = 2'b00;
  localparam logic [1:0] CMD_STOP_S = 2'b01;
  localparam logic [1:0] CMD_STOP_P = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [2:0] r_state;
  logic       r_cur_m;
  logic [1:0] r_cur_s;
  logic       r_cur_p;
  logic       r_stop_type;  // 1 = preempt (STOP_P), 0 = split (STOP_S)
  logic       r_rr;
  logic [7:0] r_timer;
  logic [2:0] r_bus_state;

  logic       w_v0;
  logic       w_v1;
  logic       w_win;
  logic [1:0] w_own_st;
  logic       w_contend;
  logic       w_oth_prio;
  logic [7:0] w_timer_inc;
  logic [1:0] w_cmd;

  assign w_v0        = req0 && (slave0 != 2'b00);
  assign w_v1        = req1 && (slave1 != 2'b00);
  // Tie with equal priority goes to the master that did not win last time.
  assign w_win       = (w_v0 && w_v1) ? ((prio0 != prio1) ? prio1 : ~r_rr) : w_v1;
  assign w_own_st    = r_cur_m ? state1 : state0;
  assign w_contend   = r_cur_m ? w_v0 : w_v1;
  assign w_oth_prio  = r_cur_m ? prio0 : prio1;
  assign w_timer_inc = (r_timer == 8'hFF) ? r_timer : r_timer + 8'd1;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state     <= S_IDLE;
      r_cur_m     <= 1'b0;
      r_cur_s     <= 2'b00;
      r_cur_p     <= 1'b0;
      r_stop_type <= 1'b0;
      r_rr        <= 1'b1;
      r_timer     <= 8'd0;
      r_bus_state <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_v0 || w_v1) begin
            r_cur_m <= w_win;
            r_cur_s <= w_win ? slave1 : slave0;
            r_cur_p <= w_win ? prio1 : prio0;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_timer <= 8'd0;
          r_state <= S_ACK;
        end
        S_ACK: begin
          if (w_own_st == ST_COM) begin
            r_bus_state <= {r_cur_m, r_cur_s};
            r_timer     <= 8'd0;
            r_state     <= S_COM;
          end else if (w_own_st == ST_NAK) begin
            r_state <= S_RELEASE;
          end else if (w_own_st == ST_WAIT) begin
            if (r_timer == TO_LAST) r_state <= S_RELEASE;
            else                    r_timer <= w_timer_inc;
          end
        end
        S_COM: begin
          if (w_own_st == ST_END) begin
            r_state <= S_RELEASE;
          end else if (w_contend && w_oth_prio && !r_cur_p) begin
            r_stop_type <= 1'b1;
            r_state     <= S_STOP;
          end else if (w_contend && (r_timer == TO_LAST)) begin
            r_stop_type <= 1'b0;
            r_state     <= S_STOP;
          end else if (w_contend) begin
            r_timer <= w_timer_inc;
          end
        end
        S_STOP: begin
          if (w_own_st == ST_END) r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          r_bus_state <= 3'b000;
          r_rr        <= r_cur_m;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cmd = CMD_WAIT;
    if (r_state == S_GRANT)     w_cmd = CMD_CLEAR;
    else if (r_state == S_STOP) w_cmd = r_stop_type ? CMD_STOP_P : CMD_STOP_S;
    cmd0 = r_cur_m ? CMD_WAIT : w_cmd;
    cmd1 = r_cur_m ? w_cmd : CMD_WAIT;
  end

  assign bus_state = r_bus_state;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_bus_scheduler.sv
// Directed bench for bus_scheduler (TIMEOUT=4): grant, round-robin, preemption,
// split, nak/ack timeout, end_com priority and asynchronous reset.
module tb_bus_scheduler;

  logic       clk = 1'b0;
  logic       rstN;
  logic       req0, req1, prio0, prio1;
  logic [1:0] slave0, slave1, state0, state1;
  logic [1:0] cmd0, cmd1;
  logic [2:0] bus_state;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  bus_scheduler #(.TIMEOUT(4)) dut (
    .clk(clk), .rstN(rstN),
    .req0(req0), .req1(req1),
    .slave0(slave0), .slave1(slave1),
    .prio0(prio0), .prio1(prio1),
    .state0(state0), .state1(state1),
    .cmd0(cmd0), .cmd1(cmd1),
    .bus_state(bus_state), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus_state !== 3'b000) begin n_err++; $display("FAIL reset_bus: got %b want 000", bus_state); end
    n_cmp++; if (cmd0 !== 2'b00) begin n_err++; $display("FAIL reset_cmd0: got %b want 00", cmd0); end
    n_cmp++; if (cmd1 !== 2'b00) begin n_err++; $display("FAIL reset_cmd1: got %b want 00", cmd1); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rstN = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_no_req_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic m;
    req0 = 1; req1 = 1; prio0 = 0; prio1 = 0; slave0 = 2'd1; slave1 = 2'd1;
    state0 = 2'b10; state1 = 2'b10;
    for (int i = 0; i < 3; i++) begin
      m = (i == 1);
      @(negedge clk);
      n_cmp++; if ((m ? cmd1 : cmd0) !== 2'b11) begin n_err++; $display("FAIL rr_clear_%0d: got %b want 11", i, m ? cmd1 : cmd0); end
      n_cmp++; if ((m ? cmd0 : cmd1) !== 2'b00) begin n_err++; $display("FAIL rr_loser_wait_%0d: got %b want 00", i, m ? cmd0 : cmd1); end
      state0 = 2'b11; state1 = 2'b11;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (bus_state !== {m, 2'b01}) begin n_err++; $display("FAIL rr_bus_%0d: got %b want %b", i, bus_state, {m, 2'b01}); end
      state0 = 2'b00; state1 = 2'b00;
      @(negedge clk);
      state0 = 2'b10; state1 = 2'b10;
      if (i == 2) begin req0 = 0; req1 = 0; end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || bus_state !== 3'b000) begin n_err++; $display("FAIL rr_idle_%0d: got busy=%b bus=%b want busy=0 bus=000", i, busy, bus_state); end
    end
  endtask

  task automatic test_single();
    req0 = 1; slave0 = 2'd2; state0 = 2'b10;
    @(negedge clk);
    n_cmp++; if (cmd0 !== 2'b11) begin n_err++; $display("FAIL single_clear: got %b want 11", cmd0); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    req0 = 0;
    @(negedge clk);
    n_cmp++; if (cmd0 !== 2'b00) begin n_err++; $display("FAIL single_clear_one_cycle: got %b want 00", cmd0); end
    n_cmp++; if (bus_state !== 3'b000) begin n_err++; $display("FAIL single_ack_bus: got %b want 000", bus_state); end
    state0 = 2'b11;
    @(negedge clk);
    n_cmp++; if (bus_state !== 3'b010) begin n_err++; $display("FAIL single_com_bus: got %b want 010", bus_state); end
    state0 = 2'b00;
    @(negedge clk);
    n_cmp++; if (bus_state !== 3'b010 || busy !== 1'b1) begin n_err++; $display("FAIL single_release: got bus=%b busy=%b want bus=010 busy=1", bus_state, busy); end
    @(negedge clk);
    n_cmp++; if (bus_state !== 3'b000 || busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got bus=%b busy=%b want bus=000 busy=0", bus_state, busy); end
    state0 = 2'b10;
  endtask

  task automatic test_preempt();
    req0 = 1; slave0 = 2'd2; prio0 = 0; state0 = 2'b10;
    @(negedge clk);
    n_cmp++; if (cmd0 !== 2'b11) begin n_err++; $display("FAIL pre_clear0: got %b want 11", cmd0); end
    req0 = 0; state0 = 2'b11;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus_state !== 3'b010) begin n_err++; $display("FAIL pre_com_bus: got %b want 010", bus_state); end
    req1 = 1; prio1 = 1; slave1 = 2'd3; state1 = 2'b10;
    @(negedge clk);
    n_cmp++; if (cmd0 !== 2'b10) begin n_err++; $display("FAIL pre_stop_p: got %b want 10", cmd0); end
    n_cmp++; if (cmd1 !== 2'b00) begin n_err++; $display("FAIL pre_other_wait: got %b want 00", cmd1); end
    @(negedge clk);
    n_cmp++; if (cmd0 !== 2'b10) begin n_err++; $display("FAIL pre_stop_p_held: got %b want 10", cmd0); end
    state0 = 2'b00;
    @(negedge clk);
    n_cmp++; if (cmd0 !== 2'b00 || bus_state !== 3'b010) begin n_err++; $display("FAIL pre_release: got cmd0=%b bus=%b want cmd0=00 bus=010", cmd0, bus_state); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL pre_idle: got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (cmd1 !== 2'b11) begin n_err++; $display("FAIL pre_clear1: got %b want 11", cmd1); end
    req1 = 0; state1 = 2'b11;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus_state !== 3'b111) begin n_err++; $display("FAIL pre_bus_m1: got %b want 111", bus_state); end
    state1 = 2'b00;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL pre_done_idle: got %b want 0", busy); end
    prio1 = 0; state1 = 2'b10; state0 = 2'b10;
  endtask

  task automatic test_split();
    req1 = 1; slave1 = 2'd2; prio1 = 0; state1 = 2'b10;
    @(negedge clk);
    n_cmp++; if (cmd1 !== 2'b11) begin n_err++; $display("FAIL split_clear1: got %b want 11", cmd1); end
    req1 = 0; state1 = 2'b11;
    @(negedge clk);
    req0 = 1; slave0 = 2'd1; prio0 = 0; state0 = 2'b10;
    @(negedge clk);
    n_cmp++; if (bus_state !== 3'b110) begin n_err++; $display("FAIL split_com_bus: got %b want 110", bus_state); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_cmp++; if (cmd1 !== 2'b00) begin n_err++; $display("FAIL split_early_%0d: got %b want 00", i, cmd1); end
    end
    @(negedge clk);
    n_cmp++; if (cmd1 !== 2'b01) begin n_err++; $display("FAIL split_stop_s: got %b want 01", cmd1); end
    n_cmp++; if (cmd0 !== 2'b00) begin n_err++; $display("FAIL split_other_wait: got %b want 00", cmd0); end
    state1 = 2'b00;
    @(negedge clk);
    n_cmp++; if (cmd1 !== 2'b00) begin n_err++; $display("FAIL split_release_cmd: got %b want 00", cmd1); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || bus_state !== 3'b000) begin n_err++; $display("FAIL split_idle: got busy=%b bus=%b want busy=0 bus=000", busy, bus_state); end
    @(negedge clk);
    n_cmp++; if (cmd0 !== 2'b11) begin n_err++; $display("FAIL split_clear0: got %b want 11", cmd0); end
    req0 = 0; state0 = 2'b11;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus_state !== 3'b001) begin n_err++; $display("FAIL split_bus_m0: got %b want 001", bus_state); end
    state0 = 2'b00; state1 = 2'b10;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL split_done_idle: got %b want 0", busy); end
    state0 = 2'b10;
  endtask

  task automatic test_nak_timeout();
    req0 = 1; slave0 = 2'd3; state0 = 2'b10;
    @(negedge clk);
    n_cmp++; if (cmd0 !== 2'b11) begin n_err++; $display("FAIL nak_clear: got %b want 11", cmd0); end
    req0 = 0; state0 = 2'b01;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || bus_state !== 3'b000) begin n_err++; $display("FAIL nak_ack: got busy=%b bus=%b want busy=1 bus=000", busy, bus_state); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || bus_state !== 3'b000) begin n_err++; $display("FAIL nak_release: got busy=%b bus=%b want busy=1 bus=000", busy, bus_state); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || bus_state !== 3'b000) begin n_err++; $display("FAIL nak_idle: got busy=%b bus=%b want busy=0 bus=000", busy, bus_state); end
    req0 = 1; state0 = 2'b10;
    @(negedge clk);
    n_cmp++; if (cmd0 !== 2'b11) begin n_err++; $display("FAIL ackto_clear: got %b want 11", cmd0); end
    req0 = 0;
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || cmd0 !== 2'b00) begin n_err++; $display("FAIL ackto_still_ack: got busy=%b cmd0=%b want busy=1 cmd0=00", busy, cmd0); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || bus_state !== 3'b000) begin n_err++; $display("FAIL ackto_release: got busy=%b bus=%b want busy=1 bus=000", busy, bus_state); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || bus_state !== 3'b000) begin n_err++; $display("FAIL ackto_idle: got busy=%b bus=%b want busy=0 bus=000", busy, bus_state); end
  endtask

  task automatic test_end_com_wins();
    req0 = 1; slave0 = 2'd1; prio0 = 0; state0 = 2'b10;
    @(negedge clk);
    req0 = 0; state0 = 2'b11;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus_state !== 3'b001) begin n_err++; $display("FAIL ecw_com_bus: got %b want 001", bus_state); end
    req1 = 1; prio1 = 1; slave1 = 2'd2; state1 = 2'b10; state0 = 2'b00;
    @(negedge clk);
    n_cmp++; if (cmd0 !== 2'b00 || busy !== 1'b1) begin n_err++; $display("FAIL ecw_no_stop: got cmd0=%b busy=%b want cmd0=00 busy=1", cmd0, busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || bus_state !== 3'b000) begin n_err++; $display("FAIL ecw_idle: got busy=%b bus=%b want busy=0 bus=000", busy, bus_state); end
    @(negedge clk);
    n_cmp++; if (cmd1 !== 2'b11) begin n_err++; $display("FAIL ecw_clear1: got %b want 11", cmd1); end
    req1 = 0; prio1 = 0; state1 = 2'b01;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ecw_done_idle: got %b want 0", busy); end
    state1 = 2'b10; state0 = 2'b10;
  endtask

  task automatic test_reset_mid_com();
    req0 = 1; slave0 = 2'd3; state0 = 2'b10;
    @(negedge clk);
    req0 = 0; state0 = 2'b11;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus_state !== 3'b011) begin n_err++; $display("FAIL rst_pre_bus: got %b want 011", bus_state); end
    #2 rstN = 1'b0;
    #1;
    n_cmp++; if (bus_state !== 3'b000) begin n_err++; $display("FAIL rst_async_bus: got %b want 000", bus_state); end
    n_cmp++; if (cmd0 !== 2'b00 || cmd1 !== 2'b00) begin n_err++; $display("FAIL rst_async_cmd: got %b/%b want 00/00", cmd0, cmd1); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    @(negedge clk);
    rstN = 1'b1; req0 = 1; slave0 = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || cmd0 !== 2'b00) begin n_err++; $display("FAIL rst_slave0_ignored_%0d: got busy=%b cmd0=%b want busy=0 cmd0=00", i, busy, cmd0); end
    end
    req0 = 0;
  endtask

  initial begin
    rstN = 1'b0;
    req0 = 0; req1 = 0; prio0 = 0; prio1 = 0;
    slave0 = 2'd0; slave1 = 2'd0; state0 = 2'b10; state1 = 2'b10;
    test_reset();
    test_round_robin();
    test_single();
    test_preempt();
    test_split();
    test_nak_timeout();
    test_end_com_wins();
    test_reset_mid_com();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
